// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of JK latch cells: turns LOAD/SET/CLEAR/TOGGLE/COUNT/
// BANKRST/READ commands into j/k vectors plus one strobe, then reads the bank back.
module jk_bank_sequencer #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_mask,
  output logic [WIDTH-1:0] bank_j,
  output logic [WIDTH-1:0] bank_k,
  output logic             bank_clk,
  output logic             bank_rst,
  input  logic [WIDTH-1:0] bank_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_STROBE, S_SETTLE, S_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_SET    = 3'd2,
    OP_CLEAR  = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_READ   = 3'd5,
    OP_COUNT  = 3'd6,
    OP_BANKRST = 3'd7
  } op_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  j_q, j_d, k_q, k_d, exp_q, exp_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              bankrst_q, bankrst_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]  acc_j, acc_k, acc_e, cnt_jk;
  logic              carry;

  // Per-op j/k and expected value, computed from the bank snapshot at accept time.
  // NOTE: every output gets a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    cnt_jk = '0;
    carry  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_jk[i] = carry;
      carry     = carry & bank_q[i];
    end

    acc_j = '0;
    acc_k = '0;
    acc_e = '0;
    case (op_e'(cmd_op))
      OP_LOAD: begin
        acc_j = cmd_data & cmd_mask;
        acc_k = ~cmd_data & cmd_mask;
        acc_e = (bank_q & ~cmd_mask) | (cmd_data & cmd_mask);
      end
      OP_SET: begin
        acc_j = cmd_mask;
        acc_e = bank_q | cmd_mask;
      end
      OP_CLEAR: begin
        acc_k = cmd_mask;
        acc_e = bank_q & ~cmd_mask;
      end
      OP_TOGGLE: begin
        acc_j = cmd_mask;
        acc_k = cmd_mask;
        acc_e = bank_q ^ cmd_mask;
      end
      OP_COUNT: begin
        acc_j = cnt_jk;
        acc_k = cnt_jk;
        acc_e = bank_q + WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    k_d        = k_q;
    exp_d      = exp_q;
    bankrst_d  = bankrst_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          j_d       = acc_j;
          k_d       = acc_k;
          exp_d     = acc_e;
          bankrst_d = (op_e'(cmd_op) == OP_BANKRST);
          case (op_e'(cmd_op))
            OP_NOP: ;
            OP_READ: begin
              rsp_data_d = bank_q;
              rsp_err_d  = 1'b0;
              state_d    = S_RESP;
            end
            default: state_d = S_DRIVE;
          endcase
        end
      end
      S_DRIVE:  state_d = S_STROBE;
      S_STROBE: begin
        cnt_d   = CW'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d = bank_q;
          rsp_err_d  = (bank_q != exp_q);
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      k_q        <= '0;
      exp_q      <= '0;
      bankrst_q  <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      bankrst_q  <= bankrst_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  logic drive_phase;
  assign drive_phase = (state_q == S_DRIVE) || (state_q == S_STROBE) || (state_q == S_SETTLE);

  // j/k are forced to zero outside the drive window so the bank simply holds.
  assign bank_j    = drive_phase ? j_q : '0;
  assign bank_k    = drive_phase ? k_q : '0;
  assign bank_clk  = (state_q == S_STROBE);
  assign bank_rst  = reset | (bankrst_q & ((state_q == S_DRIVE) || (state_q == S_STROBE)));
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench for jk_bank_sequencer: behavioural JK bank, vector table plus
// hand-written reset, stall and NOP sequences, with a response scoreboard queue.
module tb_jk_bank_sequencer;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;

  localparam logic [2:0] OP_NOP = 3'd0, OP_LOAD = 3'd1, OP_SET = 3'd2, OP_CLEAR = 3'd3,
                         OP_TOGGLE = 3'd4, OP_READ = 3'd5, OP_COUNT = 3'd6, OP_BANKRST = 3'd7;

  logic             clk, reset;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data, cmd_mask;
  logic [WIDTH-1:0] bank_j, bank_k, bank_q;
  logic             bank_clk, bank_rst;
  logic             rsp_valid, rsp_ready, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  jk_bank_sequencer #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .bank_j(bank_j), .bank_k(bank_k), .bank_clk(bank_clk), .bank_rst(bank_rst),
    .bank_q(bank_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK bank with an optional stuck-at-0 fault on its outputs.
  logic [WIDTH-1:0] bank_state;
  logic [WIDTH-1:0] stuck_mask;
  always @(posedge bank_clk or posedge bank_rst) begin
    if (bank_rst) bank_state <= '0;
    else begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({bank_j[i], bank_k[i]})
          2'b10: bank_state[i] <= 1'b1;
          2'b01: bank_state[i] <= 1'b0;
          2'b11: bank_state[i] <= ~bank_state[i];
          default: bank_state[i] <= bank_state[i];
        endcase
      end
    end
  end
  assign bank_q = bank_state & ~stuck_mask;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] exp_j;
    logic [WIDTH-1:0] exp_k;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
    logic             stuck;
    int               exp_lat;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int   lat;
    exp_t e;
    @(negedge clk);
    stuck_mask = v.stuck ? 8'h08 : 8'h00;
    check("cmd_ready_before", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_mask  = v.mask;
    sb.push_back('{data: v.exp_data, err: v.exp_err});
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    if (v.op != OP_READ) begin
      check("drive_j", {24'b0, bank_j}, {24'b0, v.exp_j});
      check("drive_k", {24'b0, bank_k}, {24'b0, v.exp_k});
      check("drive_clk", {31'b0, bank_clk}, 0);
      check("drive_bank_rst", {31'b0, bank_rst}, {31'b0, (v.op == OP_BANKRST)});
    end
    while (!rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", lat, v.exp_lat);
    e = sb.pop_front();
    check("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {31'b0, rsp_valid}, 0);
    check("cmd_ready_after_hs", {31'b0, cmd_ready}, 1);
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    exp_t e;

    vecs[0] = '{OP_BANKRST, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3 + SETTLE};
    vecs[1] = '{OP_LOAD,    8'hA5, 8'hFF, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0, 3 + SETTLE};
    vecs[2] = '{OP_SET,     8'h00, 8'h0A, 8'h0A, 8'h00, 8'hAF, 1'b0, 1'b0, 3 + SETTLE};
    vecs[3] = '{OP_CLEAR,   8'h00, 8'h21, 8'h00, 8'h21, 8'h8E, 1'b0, 1'b0, 3 + SETTLE};
    vecs[4] = '{OP_TOGGLE,  8'h00, 8'hF0, 8'hF0, 8'hF0, 8'h7E, 1'b0, 1'b0, 3 + SETTLE};
    vecs[5] = '{OP_LOAD,    8'hFE, 8'hFF, 8'hFE, 8'h01, 8'hFE, 1'b0, 1'b0, 3 + SETTLE};
    vecs[6] = '{OP_COUNT,   8'h00, 8'h00, 8'h01, 8'h01, 8'hFF, 1'b0, 1'b0, 3 + SETTLE};
    vecs[7] = '{OP_COUNT,   8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 3 + SETTLE};
    vecs[8] = '{OP_LOAD,    8'h08, 8'hFF, 8'h08, 8'hF7, 8'h00, 1'b1, 1'b1, 3 + SETTLE};
    vecs[9] = '{OP_READ,    8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0, 1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cmd_mask = '0;
    rsp_ready = 1'b0; stuck_mask = '0;
    repeat (2) @(negedge clk);
    check("reset_bank_rst", {31'b0, bank_rst}, 1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 0);
    check("reset_bank_j", {24'b0, bank_j}, 0);
    check("reset_rsp_data", {24'b0, rsp_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_ready", {31'b0, cmd_ready}, 1);
    check("post_reset_busy", {31'b0, busy}, 0);
    check("post_reset_bank_rst", {31'b0, bank_rst}, 0);

    // Reset in the middle of a TOGGLE strobe drops the command.
    cmd_valid = 1'b1; cmd_op = OP_TOGGLE; cmd_mask = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("toggle_busy", {31'b0, busy}, 1);
    @(posedge clk);
    #2;
    check("strobe_clk", {31'b0, bank_clk}, 1);
    reset = 1'b1;
    #1;
    check("async_bank_clk", {31'b0, bank_clk}, 0);
    check("async_bank_j", {24'b0, bank_j}, 0);
    check("async_bank_k", {24'b0, bank_k}, 0);
    check("async_bank_rst", {31'b0, bank_rst}, 1);
    check("async_rsp_valid", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("drop_cmd_ready", {31'b0, cmd_ready}, 1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("drop_no_rsp", seen, 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 9) stuck_mask = '0;
      if (i < 9) run_cmd(vecs[i]);
      else begin
        // Stall: hold rsp_ready low while READs pulse; nothing new is accepted.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_READ;
        sb.push_back('{data: 8'h08, err: 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("stall_read_lat1", {31'b0, rsp_valid}, 1);
        e = sb.pop_front();
        for (int c = 0; c < 10; c++) begin
          check("stall_rsp_valid", {31'b0, rsp_valid}, 1);
          check("stall_rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
          check("stall_rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("stall_cmd_ready", {31'b0, cmd_ready}, 0);
          cmd_valid = (c % 2 == 0);
          @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall_hs_rsp_valid", {31'b0, rsp_valid}, 0);
        check("stall_hs_cmd_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk);
        check("stall_no_extra_rsp", {31'b0, rsp_valid}, 0);
        run_cmd(vecs[9]);
      end
    end

    // NOP: accepted but produces nothing and never leaves IDLE.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_NOP;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("nop_cmd_ready", {31'b0, cmd_ready}, 1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || !cmd_ready) seen++;
    end
    check("nop_no_rsp", seen, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Command-driven controller for a bank of WIDTH JK latch cells that share one strobe clock and one reset.
- Accepts one command at a time over a valid/ready interface and translates it into per-bit j/k vectors plus a strobe pulse.
- Holds j/k stable through a settle window, then reads the bank back and returns the result with a mismatch flag.
- Sits between a register-file/test master and the JK storage bank; the only block allowed to drive the bank's j, k, clk and reset.

Parameters:
WIDTH, 8, number of JK cells in the bank (>=2)
SETTLE, 2, cycles j/k are held after the strobe before readback (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  0 NOP, 1 LOAD, 2 SET, 3 CLEAR, 4 TOGGLE, 5 READ, 6 COUNT, 7 BANKRST
cmd_data  input  WIDTH  LOAD data
cmd_mask  input  WIDTH  bit select for LOAD/SET/CLEAR/TOGGLE
bank_j  output  WIDTH  j inputs of the bank
bank_k  output  WIDTH  k inputs of the bank
bank_clk  output  1  strobe to the bank clk input
bank_rst  output  1  bank reset
bank_q  input  WIDTH  bank out1 vector
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_data  output  WIDTH  bank value read back
rsp_err  output  1  readback differs from expected value
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-high. While reset is high or just released:
  - state = IDLE.
  - bank_j, bank_k, bank_clk, rsp_valid, rsp_data and rsp_err are all 0.
  - bank_rst = 1 while reset is high (reset OR internal request).
- An in-flight command is dropped by reset; no response is produced.
- FSM states: IDLE, DRIVE, STROBE, SETTLE, RESP.
- cmd_ready = (state == IDLE). Accept = cmd_valid & cmd_ready.
- On accept, the controller captures op, data and mask, snapshots bank_q into S, and computes the expected value E. Then:
  - NOP: remain IDLE; no response.
  - READ: go to RESP next cycle with rsp_data = S, rsp_err = 0.
  - All other ops: go to DRIVE.
- j/k/E per op (i = bit index):
  - LOAD: j = data & mask; k = ~data & mask; E = (S & ~mask) | (data & mask).
  - SET: j = mask; k = 0; E = S | mask.
  - CLEAR: j = 0; k = mask; E = S & ~mask.
  - TOGGLE: j = k = mask; E = S ^ mask.
  - COUNT: j[0] = k[0] = 1; j[i] = k[i] = &S[i-1:0]; E = (S + 1) mod 2^WIDTH. All ones wraps to 0.
  - BANKRST: j = k = 0; bank_rst = 1 in DRIVE and STROBE; E = 0.
- Cycle timing after accept at cycle 0:
  - DRIVE (cycle 1): j/k driven, bank_clk = 0.
  - STROBE (cycle 2): bank_clk = 1, j/k unchanged.
  - SETTLE (cycles 3 .. 2+SETTLE): bank_clk = 0, j/k held. An internal counter loads SETTLE-1 and counts down to 0.
  - On the last SETTLE cycle, bank_q is registered into rsp_data, and rsp_err = (bank_q != E).
  - RESP (from cycle 3+SETTLE): rsp_valid = 1.
- Command latency from accept to rsp_valid = 3 + SETTLE cycles; READ takes 1 cycle.
- bank_j and bank_k are 0 in every state other than DRIVE, STROBE and SETTLE, so the bank holds its value.
- Responses:
  - rsp_valid, rsp_data and rsp_err hold stable until rsp_valid & rsp_ready.
  - On that handshake: next state IDLE, rsp_valid = 0. rsp_data and rsp_err keep their last values.
  - cmd_ready first rises the cycle after the response handshake; there is no back-to-back overlap.
- cmd_valid while busy is ignored and is not queued.
- Illegal conditions are impossible: every op encoding is defined.

Test Plan:
- Reset asserted mid-STROBE of a TOGGLE, with SETTLE = 2, WIDTH = 8 → outputs go to 0 asynchronously and bank_rst = 1; after release, state is IDLE, cmd_ready = 1, and no rsp_valid ever appears.
- BANKRST, then LOAD data = 8'hA5, mask = 8'hFF → first response rsp_data = 8'h00, err = 0; second response 8'hA5, err = 0. rsp_valid appears exactly 5 cycles after each accept.
- From 8'hA5: SET mask 8'h0A → 8'hAF; CLEAR mask 8'h21 → 8'h8E; TOGGLE mask 8'hF0 → 8'h7E. Each response has err = 0, and j/k match the per-op formulas in DRIVE.
- COUNT from 8'hFE → 8'hFF; COUNT again → 8'h00 (wrap), with j = k = 8'hFF on the wrap step; err = 0 both times.
- Bank model forced stuck-at-0 on bit 3, then LOAD 8'h08 → rsp_data = 8'h00, rsp_err = 1.
- rsp_ready held low 10 cycles while cmd_valid pulses with READ → response fields stay stable, cmd_ready stays 0, and the extra command is not accepted. READ after release → response 1 cycle after accept with err = 0. NOP → cmd_ready stays 1 and no response.
